seq_mag_comp: RTL

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

---
 rtl/seq_mag_comp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_mag_comp.sv
// Nibble-serial unsigned magnitude comparator, LSB nibble first; result valid WIDTH/4 edges after accept.
// Single operand pair in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_mag_comp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             r_lt;
    logic             r_gt;
    logic             r_eq;
    logic             w_lt_nxt;
    logic             w_gt_nxt;
    logic             w_eq_nxt;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;

    assign w_a_nib = 4'(r_a >> {r_idx, 2'b00});
    assign w_b_nib = 4'(r_b >> {r_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_lt    <= w_lt_nxt;
            r_gt    <= w_gt_nxt;
            r_eq    <= w_eq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_lt_nxt    = r_lt;
        w_gt_nxt    = r_gt;
        w_eq_nxt    = r_eq;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_lt_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_eq_nxt    = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Equal nibbles keep the lower-order verdict; any difference overrides it.
                if (w_a_nib > w_b_nib) begin
                    w_gt_nxt = 1'b1;
                    w_lt_nxt = 1'b0;
                    w_eq_nxt = 1'b0;
                end else if (w_a_nib < w_b_nib) begin
                    w_lt_nxt = 1'b1;
                    w_gt_nxt = 1'b0;
                    w_eq_nxt = 1'b0;
                end
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign lt = r_lt;
    assign gt = r_gt;
    assign eq = r_eq;

endmodule
